// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the memory-stage data-access interface: access sizes and
// responder FSM states.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DsizeByte = 2'b00,
    DsizeHalf = 2'b01,
    DsizeWord = 2'b10,
    DsizeRsvd = 2'b11
  } dsize_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned CntWidth  = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between mem_unit (master) and the data-memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                 req_valid;
  logic                 req_write;
  logic [1:0]           req_dsize;
  logic                 req_loadext;
  logic [DataWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_write, req_dsize, req_loadext, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_dsize, req_loadext, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: store byte mask and merged word, load lane extract with
// sign/zero extension, and size/alignment misalign detection.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  dsize,
  input  logic [1:0]  addr_lo,
  input  logic        loadext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_mask,
  output logic [31:0] merged,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] lane_data;
  logic [31:0] bit_mask;

  always_comb begin
    ld_byte   = 8'h00;
    ld_half   = addr_lo[1] ? word[15:0] : word[31:16];
    lane_data = 32'h0;
    byte_mask = 4'b0000;
    rdata_ext = 32'h0;
    misalign  = 1'b0;

    unique case (addr_lo)
      2'd0:    ld_byte = word[31:24];
      2'd1:    ld_byte = word[23:16];
      2'd2:    ld_byte = word[15:8];
      default: ld_byte = word[7:0];
    endcase

    unique case (dsize_e'(dsize))
      DsizeByte: begin
        byte_mask = 4'b1000 >> addr_lo;
        lane_data = {4{wdata[7:0]}};
        rdata_ext = loadext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      end
      DsizeHalf: begin
        byte_mask = addr_lo[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{wdata[15:0]}};
        rdata_ext = loadext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
        misalign  = addr_lo[0];
      end
      DsizeWord: begin
        byte_mask = 4'b1111;
        lane_data = wdata;
        rdata_ext = word;
        misalign  = |addr_lo;
      end
      default: ;
    endcase

    bit_mask = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};
    merged   = (word & ~bit_mask) | (lane_data & bit_mask);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES cycles,
// services it from the internal word array and returns a single-cycle response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic              clock,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IdxWidth = $clog2(DEPTH_WORDS);
  localparam int unsigned AddrMsb  = IdxWidth + 1;

  if (WAIT_STATES > 15) begin : g_ws_check
    $error("dmem_responder: WAIT_STATES must be 0..15");
  end

  logic [31:0] mem [DEPTH_WORDS];

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          write_q, loadext_q;
  logic [1:0]    dsize_q;
  logic [31:0]   addr_q, wdata_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic          idle, accept, req_err, do_access, store_en;
  logic          cur_write, cur_loadext;
  logic [1:0]    cur_dsize;
  logic [31:0]   cur_addr, cur_wdata, cur_word;
  logic [IdxWidth-1:0] cur_idx;
  logic [3:0]    byte_mask;
  logic [31:0]   merged, rdata_ext;
  logic          misalign;

  // In IDLE the live request drives the datapath so zero-wait and error checks see it.
  always_comb begin
    idle        = (state_q == StIdle);
    cur_write   = idle ? bus.req_write   : write_q;
    cur_dsize   = idle ? bus.req_dsize   : dsize_q;
    cur_loadext = idle ? bus.req_loadext : loadext_q;
    cur_addr    = idle ? bus.req_addr    : addr_q;
    cur_wdata   = idle ? bus.req_wdata   : wdata_q;
    cur_idx     = cur_addr[AddrMsb:2];
    cur_word    = mem[cur_idx];
    accept      = bus.req_valid & idle;
    req_err     = (cur_dsize == DsizeRsvd) | misalign | ((cur_addr >> (AddrMsb + 1)) != 32'h0);
    do_access   = (accept & ~req_err & (WAIT_STATES == 0)) |
                  ((state_q == StWait) & (cnt_q == 4'd1));
    store_en    = do_access & cur_write & (|byte_mask) & reset;
  end

  dmem_lane_align u_lane_align (
    .dsize     (cur_dsize),
    .addr_lo   (cur_addr[1:0]),
    .loadext   (cur_loadext),
    .word      (cur_word),
    .wdata     (cur_wdata),
    .byte_mask (byte_mask),
    .merged    (merged),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_ff @(posedge clock) begin
    if (store_en) begin
      mem[cur_idx] <= merged;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      dsize_q     <= 2'b00;
      loadext_q   <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            write_q   <= bus.req_write;
            dsize_q   <= bus.req_dsize;
            loadext_q <= bus.req_loadext;
            addr_q    <= bus.req_addr;
            wdata_q   <= bus.req_wdata;
            cnt_q     <= CntWidth'(WAIT_STATES);
            if (req_err) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
              rsp_err_q   <= 1'b1;
            end else if (do_access) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= cur_write ? 32'h0 : rdata_ext;
              rsp_err_q   <= 1'b0;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (do_access) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= cur_write ? 32'h0 : rdata_ext;
            rsp_err_q   <= 1'b0;
          end
        end
        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a 2-wait-state instance for sizing, extension,
// error and reset cases, and a zero-wait instance for back-to-back throughput.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder_if d0 ();
  dmem_responder_if d1 ();

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (d0.slave)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (d1.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && d0.rsp_valid === 1'b1) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected rsp_valid", 32'(d0.rsp_valid), 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("dut0 rdata", d0.rsp_rdata, e0.rdata);
        check("dut0 err", 32'(d0.rsp_err), 32'(e0.err));
        check("dut0 latency", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && d1.rsp_valid === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected rsp_valid", 32'(d1.rsp_valid), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut1 rdata", d1.rsp_rdata, e1.rdata);
        check("dut1 err", 32'(d1.rsp_err), 32'(e1.err));
        check("dut1 latency", cyc, e1.cyc);
      end
    end
  end

  task automatic set_req(input int sel, input logic v, input logic w, input logic [1:0] ds,
                         input logic ext, input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      d0.req_valid = v; d0.req_write = w; d0.req_dsize = ds;
      d0.req_loadext = ext; d0.req_addr = a; d0.req_wdata = wd;
    end else begin
      d1.req_valid = v; d1.req_write = w; d1.req_dsize = ds;
      d1.req_loadext = ext; d1.req_addr = a; d1.req_wdata = wd;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? d0.req_ready : d1.req_ready;
  endfunction

  // Presents a request, waits (bounded) for acceptance and books the expected response.
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int sel, input logic w, input logic [1:0] ds, input logic ext,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit keep_valid, input bit book, output int unsigned acc);
    bit   got = 0;
    int   ws  = (sel == 0) ? 2 : 0;
    exp_t e;
    acc = 0;
    set_req(sel, 1'b1, w, ds, ext, a, wd);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (get_ready(sel)) got = 1;
    end
    if (!got) begin
      check("req_ready timeout", 32'(get_ready(sel)), 32'd1);
    end else begin
      acc = cyc;
      if (book) begin
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc + 1 + (exp_err ? 0 : ws);
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    if (!keep_valid) set_req(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic req0(input logic w, input logic [1:0] ds, input logic ext,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    int unsigned acc;
    issue(0, w, ds, ext, a, wd, exp_rd, exp_err, 1'b0, 1'b1, acc);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  ds;
    logic        ext;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
  } b2b_t;

  b2b_t b2b[6];

  initial begin
    int unsigned acc, prev_acc;
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clock);
    check("reset req_ready", 32'(d0.req_ready), 32'd1);
    check("reset rsp_valid", 32'(d0.rsp_valid), 32'd0);
    check("reset rsp_rdata", d0.rsp_rdata, 32'h0);
    check("reset rsp_err", 32'(d0.rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Word store/load round trip
    req0(1, DsizeWord, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    req0(0, DsizeWord, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    // Byte store into lane 3 and extension variants
    req0(1, DsizeWord, 0, 32'h10, 32'h11223344, 32'h0, 0);
    req0(1, DsizeByte, 0, 32'h13, 32'hABCDEF80, 32'h0, 0);
    req0(0, DsizeByte, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    req0(0, DsizeByte, 0, 32'h13, 32'h0, 32'h00000080, 0);
    req0(0, DsizeWord, 0, 32'h10, 32'h0, 32'h11223380, 0);
    req0(0, DsizeByte, 1, 32'h10, 32'h0, 32'h00000011, 0);
    // Half-word lanes and misalignment errors
    req0(1, DsizeWord, 0, 32'h10, 32'hCAFE8001, 32'h0, 0);
    req0(0, DsizeHalf, 1, 32'h12, 32'h0, 32'hFFFF8001, 0);
    req0(0, DsizeHalf, 1, 32'h10, 32'h0, 32'hFFFFCAFE, 0);
    req0(0, DsizeHalf, 0, 32'h10, 32'h0, 32'h0000CAFE, 0);
    req0(1, DsizeHalf, 0, 32'h11, 32'h00001234, 32'h0, 1);
    req0(0, DsizeHalf, 1, 32'h11, 32'h0, 32'h0, 1);
    req0(0, DsizeWord, 0, 32'h12, 32'h0, 32'h0, 1);
    req0(0, DsizeWord, 0, 32'h10, 32'h0, 32'hCAFE8001, 0);
    // Out-of-range and reserved size never touch the array
    req0(1, DsizeWord, 0, 32'h0, 32'h00000077, 32'h0, 0);
    req0(1, DsizeWord, 0, 32'h1000, 32'h55555555, 32'h0, 1);
    req0(1, DsizeRsvd, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
    req0(0, DsizeRsvd, 0, 32'h10, 32'h0, 32'h0, 1);
    req0(0, DsizeWord, 0, 32'h0, 32'h0, 32'h00000077, 0);
    req0(0, DsizeWord, 0, 32'h10, 32'h0, 32'hCAFE8001, 0);
    req0(1, DsizeWord, 0, 32'hFFC, 32'h0BADF00D, 32'h0, 0);
    req0(0, DsizeWord, 0, 32'hFFC, 32'h0, 32'h0BADF00D, 0);

    // Reset while a store is waiting: store is dropped, outputs clear at once
    req0(1, DsizeWord, 0, 32'h20, 32'h00000005, 32'h0, 0);
    req0(0, DsizeWord, 0, 32'h20, 32'h0, 32'h00000005, 0);
    for (int i = 0; i < 40 && q0.size() != 0; i++) @(negedge clock);
    @(posedge clock);
    #1;
    issue(0, 1, DsizeWord, 0, 32'h20, 32'hAAAAAAAA, 32'h0, 0, 1'b0, 1'b0, acc);
    @(negedge clock);
    check("wait req_ready", 32'(d0.req_ready), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("async reset req_ready", 32'(d0.req_ready), 32'd1);
    check("async reset rsp_valid", 32'(d0.rsp_valid), 32'd0);
    check("async reset rsp_rdata", d0.rsp_rdata, 32'h0);
    check("async reset rsp_err", 32'(d0.rsp_err), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    req0(0, DsizeWord, 0, 32'h20, 32'h0, 32'h00000005, 0);

    // Zero-wait instance: valid held high, one accept every two cycles
    b2b[0] = '{1'b1, DsizeWord, 1'b0, 32'h0, 32'h12345678, 32'h0};
    b2b[1] = '{1'b0, DsizeWord, 1'b0, 32'h0, 32'h0, 32'h12345678};
    b2b[2] = '{1'b0, DsizeHalf, 1'b0, 32'h2, 32'h0, 32'h00005678};
    b2b[3] = '{1'b0, DsizeByte, 1'b1, 32'h0, 32'h0, 32'h00000012};
    b2b[4] = '{1'b1, DsizeHalf, 1'b0, 32'h2, 32'h0000BEEF, 32'h0};
    b2b[5] = '{1'b0, DsizeWord, 1'b0, 32'h0, 32'h0, 32'h1234BEEF};
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1, b2b[i].w, b2b[i].ds, b2b[i].ext, b2b[i].a, b2b[i].wd, b2b[i].rd, 1'b0,
            (i != 5), 1'b1, acc);
      if (i != 0) check("b2b accept spacing", acc - prev_acc, 32'd2);
      prev_acc = acc;
    end

    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clock);
    check("dut0 responses outstanding", q0.size(), 32'd0);
    check("dut1 responses outstanding", q1.size(), 32'd0);
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
